// File: rtl/payload_arb_pkg.sv
// Shared constants and sizing helper for the payload arbiter slice.
// No logic; imported by the picker and the arbiter top.
package payload_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width for n PEs, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/payload_arb_picker.sv
// Rotate-priority encoder: first set bit of pending at or above rr_ptr, wrapping.
// Purely combinational, zero latency; no backpressure (result is consumed every cycle).
module payload_arb_picker
  import payload_arb_pkg::*;
#(
  parameter int NUM_PE = 10,
  parameter int ID_W   = id_width(NUM_PE)
) (
  input  logic [NUM_PE-1:0] pending,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic              sel_valid,
  output logic [ID_W-1:0]   sel_id
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PE) idx = idx - NUM_PE;
      if (pending[idx]) begin
        sel_valid = 1'b1;
        sel_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/payload_arbiter_rr.sv
// Orders one-shot PE requests into an ID FIFO and grants the payload channel to the head until last.
// Request to grant is two cycles on an idle block; PEs are held off by a pending/queued bitmap, never by a full FIFO.
module payload_arbiter_rr
  import payload_arb_pkg::*;
#(
  parameter int NUM_PE  = 10,
  parameter int ID_W    = id_width(NUM_PE),
  parameter int RR_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PE-1:0] req,
  input  logic              last,
  output logic [ID_W-1:0]   grant_id,
  output logic              grant_valid,
  output logic [NUM_PE-1:0] grant_onehot,
  output logic              grant_start,
  output logic [NUM_PE-1:0] pending,
  output logic [ID_W:0]     queue_count
);

  logic [NUM_PE-1:0] pending_q, pending_d;
  logic [NUM_PE-1:0] in_queue_q, in_queue_d;
  logic [ID_W-1:0]   fifo_q [NUM_PE];
  logic [ID_W-1:0]   fifo_d [NUM_PE];
  logic [ID_W-1:0]   head_q, head_d;
  logic [ID_W-1:0]   tail_q, tail_d;
  logic [ID_W:0]     count_q, count_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              grant_start_q, grant_start_d;

  logic              sel_valid;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   pick_base;
  logic [NUM_PE-1:0] accept;
  logic              push;
  logic              pop;

  // NUM_PE need not be a power of two, so wrap explicitly.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_PE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pick_base = (RR_MODE == ARB_RR) ? rr_ptr_q : '0;

  payload_arb_picker #(
    .NUM_PE (NUM_PE),
    .ID_W   (ID_W)
  ) u_picker (
    .pending   (pending_q),
    .rr_ptr    (pick_base),
    .sel_valid (sel_valid),
    .sel_id    (sel_id)
  );

  assign accept = req & ~pending_q & ~in_queue_q;
  assign push   = sel_valid;
  assign pop    = last && (count_q != '0);

  always_comb begin
    pending_d     = pending_q | accept;
    in_queue_d    = in_queue_q;
    fifo_d        = fifo_q;
    head_d        = head_q;
    tail_d        = tail_q;
    rr_ptr_d      = rr_ptr_q;
    count_d       = count_q + (ID_W+1)'(push) - (ID_W+1)'(pop);
    grant_start_d = (push && count_q == '0) ||
                    (pop && count_q >= (ID_W+1)'(2)) ||
                    (pop && push && count_q == (ID_W+1)'(1));
    if (push) begin
      pending_d[sel_id]  = 1'b0;
      in_queue_d[sel_id] = 1'b1;
      fifo_d[tail_q]     = sel_id;
      tail_d             = wrap_inc(tail_q);
      rr_ptr_d           = wrap_inc(sel_id);
    end
    // The pushed id is never the head: it was pending, hence not yet queued.
    if (pop) begin
      in_queue_d[fifo_q[head_q]] = 1'b0;
      head_d                     = wrap_inc(head_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q     <= '0;
      in_queue_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rr_ptr_q      <= '0;
      grant_start_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      in_queue_q    <= in_queue_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_start_q <= grant_start_d;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_comb begin
    grant_valid  = (count_q != '0);
    grant_id     = grant_valid ? fifo_q[head_q] : '0;
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant_id] = 1'b1;
  end

  assign grant_start = grant_start_q;
  assign pending     = pending_q;
  assign queue_count = count_q;

endmodule

// File: doc/payload_arbiter_rr.md
Name: payload_arbiter_rr

Overview:
Parametrised successor to the payload arbiter. Collects one-shot transmit requests from NUM_PE processing elements and orders them into an ID FIFO. It grants the shared payload channel to the FIFO head until that PE signals last. Adds selectable fixed or round-robin ordering of simultaneous requests, duplicate-request suppression, explicit valid/one-hot grant outputs and an occupancy count. Sits between the PE array and the payload mux/serializer.

Parameters:
NUM_PE, 10, number of requesting PEs (2..64)
ID_W, $clog2(NUM_PE), width of a PE index
RR_MODE, 1, 0 = fixed priority (lowest index first), 1 = round-robin among pending

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req  in  NUM_PE  per-PE request pulse; level is tolerated but counts as one request
last  in  1  current owner finished, 1-cycle pulse
grant_id  out  ID_W  PE index at FIFO head; selects payload mux
grant_valid  out  1  FIFO non-empty, grant_id meaningful
grant_onehot  out  NUM_PE  decoded grant_id, all-zero when !grant_valid
grant_start  out  1  1-cycle pulse in the first cycle a new owner is at head
pending  out  NUM_PE  latched requests not yet enqueued
queue_count  out  ID_W+1  FIFO occupancy, 0..NUM_PE

Behaviour:
- Reset (rst_n=0 at a clk edge): pending, in_queue bitmap, FIFO pointers, queue_count, rr_ptr, grant_start all 0. grant_id=0, grant_valid=0, grant_onehot=0. Reset mid-operation discards all queued and pending work with no drain.
- Request capture: pending[i] sets on req[i]. req[i] is ignored while pending[i] or in_queue[i] is 1, so a PE occupies at most one slot. The FIFO of depth NUM_PE therefore never overflows; no full flag is needed.
- Enqueue: each cycle, if pending != 0, exactly one index k is selected by the picker.
  - k is pushed to the FIFO tail; pending[k] clears; in_queue[k] sets.
  - Fixed mode: k = lowest set index.
  - RR mode: k = first set index searching upward from rr_ptr, wrapping at NUM_PE-1 -> 0. On each push, rr_ptr <= (k+1) mod NUM_PE.
- Dequeue: last with queue_count!=0 pops the head and clears in_queue[head]. last with queue_count==0 is ignored; no state changes.
- Push and pop in the same cycle: queue_count is unchanged. If queue_count was 1, the pushed entry becomes head next cycle.
- Popped PE: may re-request from the cycle after the pop. A req arriving in the same cycle as its pop is ignored because in_queue is still 1.
- queue_count next value = count + push - pop.
- grant_valid = (queue_count != 0). grant_id = FIFO head. All grant outputs are combinational from registered state.
- grant_start is registered and asserts in cycle t+1 iff at cycle t either:
  - push with count==0, or
  - pop with count>=2, or
  - pop and push with count==1.
  It never asserts while grant_valid=0.
- Latency: req at edge t -> pending at t+1 -> head at t+2 if FIFO empty. A lone request on an idle block gives grant_valid and grant_start at t+2.
- Pointers wrap modulo NUM_PE. NUM_PE need not be a power of two; pointer increment uses explicit compare-and-zero.

Decomposition:
- Package payload_arb_pkg holds the clog2-based ID_W helper function and the mode constants ARB_FIXED=0 and ARB_RR=1.
- Sub-module payload_arb_picker: combinational rotate-priority encoder. Inputs are pending and rr_ptr; outputs are sel_valid and sel_id. Fixed mode is obtained by tying rr_ptr to 0.
- Top level holds the pending/in_queue registers, FIFO storage, pointers and grant_start logic.

Test Plan:
- Reset mid-operation: rst_n low with 3 entries queued -> next cycle queue_count=0, grant_valid=0, pending=0, grant_onehot=0.
- Single request: req=1<<3 at t0 -> t0+2 grant_valid=1, grant_id=3, grant_onehot=0x008, grant_start=1 for one cycle. last at t0+4 -> t0+5 grant_valid=0.
- Simultaneous requests: req for PE1, PE5, PE9 in one cycle.
  - RR_MODE=0: head sequence 1,5,9, each new head shown after a last.
  - RR_MODE=1 with rr_ptr=6 beforehand: sequence 9,1,5, and rr_ptr=6 after the third push.
- Duplicate suppression: req[2] pulsed on 4 consecutive cycles and again while queued -> queue_count peaks at 1, single grant to PE2.
- Push and pop together: head=4, count=1, pending[7]=1, last asserted -> next cycle grant_id=7, grant_start=1, queue_count=1.
- Spurious last: last while queue_count=0 -> no change, grant_start stays 0. Re-request on the pop cycle is ignored; re-request one cycle later is accepted.
